// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter init value, index/tag width
// helpers and the saturating-counter update used by both lookup and training paths.
package bp_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt2_e;

  function automatic int cnt_init_f(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  localparam int CNT_W_DEF = 2;
  localparam int CNT_INIT  = cnt_init_f(CNT_W_DEF);

  function automatic int idx_w_f(input int entries);
    return $clog2(entries);
  endfunction

  // Tag covers everything above the index and the two word-offset bits.
  function automatic int tag_w_f(input int pc_w, input int entries);
    return pc_w - $clog2(entries) - 2;
  endfunction

  function automatic logic [31:0] sat_next_f(input logic [31:0] cnt, input logic taken,
                                             input int cnt_w);
    logic [31:0] c_max;
    c_max = (32'd1 << cnt_w) - 32'd1;
    if (taken) begin
      return (cnt >= c_max) ? c_max : cnt + 32'd1;
    end
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: valid/tag/target per entry, filled only by
// taken branches. Target output is forced to zero on a miss.
module bp_btb
  import bp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic [PC_W-1:0] lk_pc_i,
  output logic            hit_o,
  output logic [PC_W-1:0] target_o,
  input  logic            wr_en_i,
  input  logic [PC_W-1:0] wr_pc_i,
  input  logic [PC_W-1:0] wr_target_i
);

  localparam int IDX_W = idx_w_f(ENTRIES);
  localparam int TAG_W = tag_w_f(PC_W, ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_unused;

  assign w_lk_idx = lk_pc_i[IDX_W+1:2];
  assign w_lk_tag = lk_pc_i[PC_W-1:IDX_W+2];
  assign w_wr_idx = wr_pc_i[IDX_W+1:2];
  assign w_wr_tag = wr_pc_i[PC_W-1:IDX_W+2];
  assign w_unused = ^{lk_pc_i[1:0], wr_pc_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
    end else if (clr_i) begin
      r_valid <= '0;
    end else if (wr_en_i) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clr_i) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= wr_target_i;
    end
  end

  assign hit_o    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign target_o = hit_o ? r_target[w_lk_idx] : '0;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare direction predictor with an optional BTB, enabled by defining
// BRANCH_PREDICTOR_BTB_EN. Lookup is combinational; training happens on clk_i.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            pred_taken_o,
  output logic            pred_hit_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i,
  input  logic            clr_i
);

  localparam int               IDX_W      = idx_w_f(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_INIT_V = CNT_W'(cnt_init_f(CNT_W));

  logic [CNT_W-1:0] r_cnt [ENTRIES];
  logic [IDX_W-1:0] w_ghr_ext;
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [CNT_W-1:0] w_lk_cnt;
  logic [CNT_W-1:0] w_upd_cnt_next;

  generate
    if (HIST_W > 0) begin : g_gshare
      logic [HIST_W-1:0] r_ghr;
      // History only advances on resolved branches, never on lookups.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          r_ghr <= '0;
        end else if (clr_i) begin
          r_ghr <= '0;
        end else if (upd_valid_i) begin
          r_ghr <= HIST_W'({r_ghr, upd_taken_i});
        end
      end
      assign w_ghr_ext = IDX_W'(r_ghr);
    end else begin : g_bimodal
      assign w_ghr_ext = '0;
    end
  endgenerate

  assign w_lk_idx       = pc_i[IDX_W+1:2] ^ w_ghr_ext;
  assign w_upd_idx      = upd_pc_i[IDX_W+1:2] ^ w_ghr_ext;
  assign w_lk_cnt       = r_cnt[w_lk_idx];
  assign w_upd_cnt_next = CNT_W'(sat_next_f(32'(r_cnt[w_upd_idx]), upd_taken_i, CNT_W));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT_V;
    end else if (clr_i) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT_V;
    end else if (upd_valid_i) begin
      r_cnt[w_upd_idx] <= w_upd_cnt_next;
    end
  end

`ifdef BRANCH_PREDICTOR_BTB_EN
  logic            w_hit;
  logic [PC_W-1:0] w_target;

  bp_btb #(
    .PC_W    (PC_W),
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .lk_pc_i     (pc_i),
    .hit_o       (w_hit),
    .target_o    (w_target),
    .wr_en_i     (upd_valid_i & upd_taken_i),
    .wr_pc_i     (upd_pc_i),
    .wr_target_i (upd_target_i)
  );

  assign pred_taken_o  = w_lk_cnt[CNT_W-1] & w_hit;
  assign pred_hit_o    = w_hit;
  assign pred_target_o = w_target;
`else
  logic w_unused;
  assign w_unused = ^{pc_i[1:0], pc_i[PC_W-1:IDX_W+2], upd_pc_i[1:0],
                      upd_pc_i[PC_W-1:IDX_W+2], upd_target_i};

  assign pred_taken_o  = w_lk_cnt[CNT_W-1];
  assign pred_hit_o    = 1'b0;
  assign pred_target_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed checks of the bimodal predictor (default params) and a gshare instance (HIST_W=2).
module tb_branch_predictor;

`ifdef BRANCH_PREDICTOR_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, upd_pc, upd_target;
  logic        upd_valid, upd_taken, clr;
  logic        taken, hit;
  logic [31:0] target;
  logic [31:0] g_pc, g_upd_pc, g_upd_target;
  logic        g_upd_valid, g_upd_taken, g_clr;
  logic        g_taken, g_hit;
  logic [31:0] g_target;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predictor u_dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .pc_i          (pc),
    .pred_taken_o  (taken),
    .pred_hit_o    (hit),
    .pred_target_o (target),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target),
    .clr_i         (clr)
  );

  branch_predictor #(.HIST_W(2)) u_gs (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .pc_i          (g_pc),
    .pred_taken_o  (g_taken),
    .pred_hit_o    (g_hit),
    .pred_target_o (g_target),
    .upd_valid_i   (g_upd_valid),
    .upd_pc_i      (g_upd_pc),
    .upd_taken_i   (g_upd_taken),
    .upd_target_i  (g_upd_target),
    .clr_i         (g_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic upd_a(input logic [31:0] p, input logic t, input logic [31:0] tg);
    upd_valid = 1'b1; upd_pc = p; upd_taken = t; upd_target = tg;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic upd_g(input logic [31:0] p, input logic t, input logic [31:0] tg);
    g_upd_valid = 1'b1; g_upd_pc = p; g_upd_taken = t; g_upd_target = tg;
    @(posedge clk); #1;
    g_upd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    pc = 32'h40; upd_pc = 32'h40; upd_target = 32'h80; upd_valid = 1'b1; upd_taken = 1'b1;
    clr = 1'b0;
    g_pc = 32'h40; g_upd_pc = '0; g_upd_target = '0; g_upd_valid = 1'b0; g_upd_taken = 1'b0;
    g_clr = 1'b0;

    // Reset held with an update pending: outputs must stay zero.
    #2;
    chk("rst_taken", 32'(taken), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_target", target, 0);
    chk("rst_gs_taken", 32'(g_taken), 0);
    repeat (2) @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_taken", 32'(taken), 0);
    chk("post_rst_hit", 32'(hit), 0);

    // Two taken updates: counter 1 -> 3.
    upd_a(32'h40, 1'b1, 32'h80);
    upd_a(32'h40, 1'b1, 32'h80);
    pc = 32'h40; #1;
    chk("train_taken", 32'(taken), 1);
    chk("train_hit", 32'(hit), BTB ? 32'd1 : 32'd0);
    chk("train_target", target, BTB ? 32'h80 : 32'h0);

    // Same index, different tag.
    pc = 32'h140; #1;
    chk("alias_hit", 32'(hit), 0);
    chk("alias_taken", 32'(taken), BTB ? 32'd0 : 32'd1);

    // Saturation at top and bottom on a fresh entry.
    repeat (5) upd_a(32'h48, 1'b1, 32'h100);
    upd_a(32'h48, 1'b0, 32'h0);
    pc = 32'h48; #1;
    chk("sat_hi_taken", 32'(taken), 1);
    upd_a(32'h48, 1'b0, 32'h0);
    #1;
    chk("dec_to1_taken", 32'(taken), 0);
    repeat (3) upd_a(32'h48, 1'b0, 32'h0);
    upd_a(32'h48, 1'b1, 32'h100);
    #1;
    chk("sat_lo_taken", 32'(taken), 0);
    upd_a(32'h48, 1'b1, 32'h100);
    #1;
    chk("inc_to2_taken", 32'(taken), 1);
    chk("sat_target", target, BTB ? 32'h100 : 32'h0);

    // Update and lookup at the same index in one cycle: no bypass.
    upd_a(32'h4C, 1'b1, 32'hC0);
    pc = 32'h4C;
    upd_valid = 1'b1; upd_pc = 32'h4C; upd_taken = 1'b0; upd_target = 32'h0;
    #1;
    chk("same_cyc_old", 32'(taken), 1);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    #1;
    chk("same_cyc_new", 32'(taken), 0);

    // Update fields without upd_valid are ignored.
    upd_valid = 1'b0; upd_pc = 32'h50; upd_taken = 1'b1; upd_target = 32'h200;
    repeat (3) @(posedge clk);
    #1;
    pc = 32'h50; #1;
    chk("novalid_taken", 32'(taken), 0);
    chk("novalid_hit", 32'(hit), 0);

    // Clear wins over a simultaneous update.
    clr = 1'b1; upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80;
    @(posedge clk); #1;
    clr = 1'b0; upd_valid = 1'b0;
    pc = 32'h40; #1;
    chk("clr_taken40", 32'(taken), 0);
    chk("clr_hit40", 32'(hit), 0);
    pc = 32'h48; #1;
    chk("clr_taken48", 32'(taken), 0);
    upd_a(32'h40, 1'b1, 32'h80);
    pc = 32'h40; #1;
    chk("post_clr_taken", 32'(taken), 1);

    // Reset asserted mid-operation with an update in flight.
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_taken", 32'(taken), 0);
    chk("midrst_hit", 32'(hit), 0);
    chk("midrst_target", target, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h80;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    #1;
    chk("first_upd_taken", 32'(taken), 1);
    chk("first_upd_hit", 32'(hit), BTB ? 32'd1 : 32'd0);

    // gshare: GHR 00 -> 01 -> 11; the third update lands on 0x10^0x3 = 0x13.
    upd_g(32'h0, 1'b1, 32'h10);
    upd_g(32'h40, 1'b1, 32'h80);
    upd_g(32'h40, 1'b1, 32'h80);
    g_pc = 32'h40; #1;
    chk("gs_idx13_taken", 32'(g_taken), 1);
    chk("gs_hit", 32'(g_hit), BTB ? 32'd1 : 32'd0);
    g_pc = 32'h4C; #1;
    chk("gs_idx10_taken", 32'(g_taken), 0);
    g_pc = 32'h44; #1;
    chk("gs_idx12_taken", 32'(g_taken), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning PC and target width.
REQ-002 SHALL have parameter ENTRIES, default 64, meaning counter-table depth; must be a power of 2 and ≥4; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CNT_W, default 2, meaning saturating-counter width (≥2).
REQ-004 SHALL have parameter HIST_W, default 0, meaning global-history width; 0 gives bimodal mode, 1..IDX_W gives gshare mode.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port pc_i, input, PC_W bits: the fetch PC for lookup.
REQ-008 SHALL have port pred_taken_o, output, 1 bit: the predict-taken result for pc_i.
REQ-009 SHALL have port pred_hit_o, output, 1 bit: BTB hit for pc_i.
REQ-010 SHALL have port pred_target_o, output, PC_W bits: the predicted target for pc_i.
REQ-011 SHALL have port upd_valid_i, input, 1 bit: a resolved branch this cycle.
REQ-012 SHALL have port upd_pc_i, input, PC_W bits: the resolved branch PC.
REQ-013 SHALL have port upd_taken_i, input, 1 bit: the resolved branch direction.
REQ-014 SHALL have port upd_target_i, input, PC_W bits: the resolved branch target.
REQ-015 SHALL have port clr_i, input, 1 bit: synchronous clear of all predictor state.

Function
REQ-016 SHALL form the lookup index as pc_i[IDX_W+1:2], XORed in gshare mode with GHR zero-extended to IDX_W.
REQ-017 SHALL form the update index identically from upd_pc_i and the current GHR.
REQ-018 SHALL make lookup combinational, zero-cycle latency: pred_taken_o = MSB of the indexed counter, gated by pred_hit_o when BTB is compiled in.
REQ-019 SHALL, on upd_valid_i, increment the indexed counter if upd_taken_i and decrement it otherwise, saturating at 2^CNT_W-1 and at 0 (no wrap).
REQ-020 SHALL, on upd_valid_i with HIST_W>0, shift GHR left by one and insert upd_taken_i at bit 0; the oldest bit is discarded; GHR is updated non-speculatively only.
REQ-021 SHALL, when lookup and update hit the same index in the same cycle, return the pre-update counter value (no bypass); the new value is visible the next cycle.
REQ-022 SHALL, on clr_i, set every counter to the init value, GHR to 0 and all BTB valid bits to 0 in one cycle; clr_i has priority over a simultaneous upd_valid_i, which is dropped.
REQ-023 SHALL ignore upd_pc_i, upd_taken_i and upd_target_i when upd_valid_i=0.

Reset
REQ-024 SHALL, while rst_i=0, asynchronously set counters to CNT_INIT = 2^(CNT_W-1)-1 (weakly not-taken), GHR to 0 and BTB valid bits to 0.
REQ-025 SHALL give the following output values during reset with any pc_i: pred_taken_o=0, pred_hit_o=0, pred_target_o=0.
REQ-026 SHALL discard any update in flight when reset asserts mid-operation; the first update is accepted on the first rising edge after rst_i deasserts.

Configuration
REQ-027 SHALL, with macro BRANCH_PREDICTOR_BTB_EN defined, include a direct-mapped BTB of ENTRIES entries indexed by pc[IDX_W+1:2], each holding valid, tag pc[PC_W-1:IDX_W+2] and target.
REQ-028 SHALL, with the BTB included: report a hit when the entry is valid and its tag matches; a taken update writes valid=1, tag and target; a not-taken update leaves the BTB unchanged.
REQ-029 SHALL, with the macro undefined: tie pred_hit_o=0 and pred_target_o=0, leave pred_taken_o ungated, and ignore upd_target_i.

Structure
REQ-030 SHALL place CNT_INIT, the index/tag width helper functions and the saturating-counter update function in the shared package bp_pkg.
REQ-031 SHALL implement the BTB as the sub-module bp_btb, instantiated only under BRANCH_PREDICTOR_BTB_EN.

Verification
REQ-032 SHALL cover: after reset, pc_i=0x40 -> pred_taken_o=0, pred_hit_o=0.
REQ-033 SHALL cover: two taken updates at 0x40 with target 0x80 -> pc_i=0x40 gives pred_taken_o=1; with BTB, pred_hit_o=1 and pred_target_o=0x80.
REQ-034 SHALL cover: five taken updates at 0x40 then one not-taken -> counter 3 then 2, pred_taken_o stays 1; a further not-taken -> counter 1, pred_taken_o=0.
REQ-035 SHALL cover: ENTRIES=64, BTB on, taken update at 0x40, lookup 0x140 (same index, different tag) -> pred_hit_o=0, pred_taken_o=0.
REQ-036 SHALL cover: update and lookup at the same index in one cycle -> old value that cycle, new value next cycle; clr_i with upd_valid_i -> all counters 1, no update applied.
REQ-037 SHALL cover: HIST_W=2, taken updates set GHR=2'b11 -> a lookup at 0x40 uses index 0x10^0x3=0x13.
